// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits pulse_num_in pulses (HIGH_CYC high / LOW_CYC low) inside a WINDOW_CYC window.
// Optional macro PULSE_TRAIN_GEN_CONT_EN: seamless back-to-back windows instead of one-shot operation.
module pulse_train_gen #(
  parameter logic [31:0] WINDOW_CYC = 32'd200000000,
  parameter logic [15:0] HIGH_CYC   = 16'd1,
  parameter logic [15:0] LOW_CYC    = 16'd1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [7:0] pulse_num_in,
  output logic       pulse_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [7:0] sent_out,
  output logic       overrun_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  num_q, num_d;
  logic [31:0] tim_cnt_q, tim_cnt_d;
  logic [15:0] ph_cnt_q, ph_cnt_d;
  logic [7:0]  sent_q, sent_d;
  logic        overrun_q, overrun_d;
  logic        done_q, done_d;
  logic        win_end;

  assign win_end = (state_q != IDLE) && (tim_cnt_q == WINDOW_CYC - 32'd1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      num_q     <= 8'd0;
      tim_cnt_q <= 32'd0;
      ph_cnt_q  <= 16'd0;
      sent_q    <= 8'd0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      tim_cnt_q <= tim_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      sent_q    <= sent_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    tim_cnt_d = tim_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    sent_d    = sent_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          num_d     = pulse_num_in;
          tim_cnt_d = 32'd0;
          ph_cnt_d  = 16'd0;
          sent_d    = 8'd0;
          overrun_d = 1'b0;
          state_d   = (pulse_num_in != 8'd0) ? HIGH : HOLD;
        end
      end
      HIGH: begin
        if (ph_cnt_q == HIGH_CYC - 16'd1) begin
          ph_cnt_d = 16'd0;
          sent_d   = sent_q + 8'd1;
          state_d  = (sent_q + 8'd1 == num_q) ? HOLD : LOW;
        end else begin
          ph_cnt_d = ph_cnt_q + 16'd1;
        end
      end
      LOW: begin
        if (ph_cnt_q == LOW_CYC - 16'd1) begin
          ph_cnt_d = 16'd0;
          state_d  = HIGH;
        end else begin
          ph_cnt_d = ph_cnt_q + 16'd1;
        end
      end
      HOLD: begin
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      tim_cnt_d = tim_cnt_q + 32'd1;
    end

    // Window end overrides the phase logic; a HIGH finishing on this cycle has already counted.
    if (win_end) begin
      done_d = 1'b1;
      if (((state_q == HIGH) || (state_q == LOW)) && (sent_d < num_q)) begin
        overrun_d = 1'b1;
      end
      tim_cnt_d = 32'd0;
      ph_cnt_d  = 16'd0;
`ifdef PULSE_TRAIN_GEN_CONT_EN
      num_d   = pulse_num_in;
      sent_d  = 8'd0;
      state_d = (pulse_num_in != 8'd0) ? HIGH : HOLD;
`else
      state_d = IDLE;
`endif
    end
  end

  assign pulse_out   = (state_q == HIGH);
  assign busy_out    = (state_q != IDLE);
  assign done_out    = done_q;
  assign sent_out    = sent_q;
  assign overrun_out = overrun_q;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Generates a programmable number of pulses inside a fixed timing window; it is the stimulus/transmit end for pulse_counter.
- A loopback of pulse_out into pulse_counter's pulse_in, with matching window and HIGH_CYC=1, reproduces the requested count on the segment display.
- Used for self-test and as a test-signal source on the LED controller board.

Parameters:
- WINDOW_CYC, 200000000 (32-bit): window length in clk_in cycles. Constraint: >= 2.
- HIGH_CYC, 1 (16-bit): cycles pulse_out stays high per pulse. Constraint: >= 1.
- LOW_CYC, 1 (16-bit): cycles pulse_out stays low between pulses. Constraint: >= 1.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset; asynchronous, active-low
- start_in  input  1  start one window; sampled only in IDLE
- pulse_num_in  input  8  number of pulses requested; latched on accepted start
- pulse_out  output  1  generated pulse train
- busy_out  output  1  high while a window is running (state != IDLE)
- done_out  output  1  one-cycle strobe at window end
- sent_out  output  8  pulses completed in the current or last window
- overrun_out  output  1  sticky flag: the requested train did not fit in the window

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk_in, reset port is rst_n_in.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- Reset values:
  - pulse_out=0, busy_out=0, done_out=0, sent_out=0, overrun_out=0
  - state=IDLE, all internal counters = 0
- States: IDLE, HIGH, LOW, HOLD.
  - pulse_out=1 exactly in cycles where state==HIGH.
  - busy_out=1 whenever state!=IDLE.
- Start (IDLE, start_in=1 at edge k):
  - Latch num_q<=pulse_num_in; clear tim_cnt, ph_cnt, sent_out and overrun_out.
  - Next state is HIGH if num_q!=0, else HOLD.
  - The first pulse_out high is cycle k+1.
- HIGH:
  - Stays HIGH_CYC cycles; sent_out increments on exit.
  - Exit to HOLD if the incremented value == num_q, otherwise to LOW.
- LOW: stays LOW_CYC cycles, then returns to HIGH.
- HOLD: pulse_out=0; waits for the window end.
- Window counter:
  - tim_cnt increments every non-IDLE cycle.
  - At tim_cnt==WINDOW_CYC-1 (the window's last cycle), the next state is IDLE from any state.
  - done_out=1 for the following single cycle.
  - Window length is exactly WINDOW_CYC cycles, from k+1 to k+WINDOW_CYC.
- Overrun:
  - Condition: the window ends while state is HIGH or LOW and sent_out < num_q.
  - Action: set overrun_out (it stays set until the next accepted start) and truncate the train.
  - A HIGH phase cut off by the window end does not increment sent_out.
  - A HIGH phase completing exactly on the last cycle counts, so no overrun.
- start_in while busy: ignored. No queuing; pulse_num_in changes mid-window have no effect.
- start_in on the same cycle as done_out: accepted, because state is IDLE then. Back-to-back windows have a 1-cycle IDLE gap.
- Width/arithmetic:
  - tim_cnt is 32 bits; ph_cnt is 16 bits.
  - sent_out never exceeds num_q, so it cannot wrap.
- Reset mid-operation: immediate return to reset values. pulse_out drops asynchronously with rst_n_in.

Optional Feature:
- Macro: PULSE_TRAIN_GEN_CONT_EN.
- Defined (continuous mode):
  - At window end, the block does not enter IDLE. It relatches pulse_num_in, clears tim_cnt and sent_out, and restarts directly in HIGH, or HOLD if the count is 0.
  - Windows are seamless, with no gap.
  - done_out still strobes each window; start_in is needed only to leave IDLE after reset.
  - overrun_out is still sticky; it is cleared only by reset.
- Undefined: one-shot behaviour exactly as above.

Test Plan:
All scenarios use WINDOW_CYC=32, HIGH_CYC=1, LOW_CYC=1 unless stated.
1. Reset, then start_in with pulse_num_in=5 -> pulse_out high at cycles k+1, k+3, k+5, k+7, k+9 only; busy_out high for 32 cycles; done_out at k+33; sent_out=5; overrun_out=0.
2. pulse_num_in=0 -> pulse_out stays 0; done_out at k+33; sent_out=0.
3. pulse_num_in=20 -> 16 pulses; window ends in LOW; overrun_out=1; sent_out=16. A following start with 3 -> overrun_out clears and sent_out=3.
4. start_in re-asserted mid-window with pulse_num_in=9, after starting with 4 -> ignored; sent_out=4 at done. start_in on the done_out cycle -> new window begins next cycle.
5. Deassert rst_n_in during HIGH of the 3rd pulse -> pulse_out, busy_out and sent_out are 0 immediately; after release the block stays IDLE until start_in.
6. PULSE_TRAIN_GEN_CONT_EN defined, pulse_num_in=2 then changed to 6 mid-window -> window 1 gives 2 pulses, window 2 gives 6; done_out every 32 cycles with no IDLE gap. Loopback into pulse_counter with a matching window -> reported count equals pulse_num_in.
